mult_dispatch: RTL and testbench
================================

MULT_DISPATCH -- requirements
Module: mult_dispatch

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: operand width; product width 2*WIDTH.
REQ-002 The block SHALL have parameter TIMEOUT, default 15: maximum WAIT cycles before abort (used only with the macro).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operand pair offered.
REQ-006 The block SHALL have port in_a, input, WIDTH bits: first operand.
REQ-007 The block SHALL have port in_b, input, WIDTH bits: second operand.
REQ-008 The block SHALL have port in_ready, output, 1 bit: dispatcher can accept an operand pair.
REQ-009 The block SHALL have port start, output, 1 bit: one-cycle pulse to the multiplier controller.
REQ-010 The block SHALL have port op_a, output, WIDTH bits: latched first operand to the multiplier datapath.
REQ-011 The block SHALL have port op_b, output, WIDTH bits: latched second operand to the multiplier datapath.
REQ-012 The block SHALL have port done, input, 1 bit: level completion flag from the multiplier controller.
REQ-013 The block SHALL have port product, input, 2*WIDTH bits: multiplier result.
REQ-014 The block SHALL have port out_valid, output, 1 bit: result available.
REQ-015 The block SHALL have port out_data, output, 2*WIDTH bits: captured result.
REQ-016 The block SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-017 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-018 The block SHALL have port timeout_err, output, 1 bit: sticky abort flag.

Function
REQ-019 The FSM SHALL have four states: IDLE, LAUNCH, WAIT, HOLD.
REQ-020 IDLE: in_ready SHALL be 1; in_valid=1 at a clk edge SHALL latch in_a/in_b into op_a/op_b and go to LAUNCH.
REQ-021 In every state other than IDLE, in_ready SHALL be 0; offered operands SHALL be ignored.
REQ-022 LAUNCH: start SHALL be 1 for exactly that one cycle; clear the done-low flag and wait_cnt; go to WAIT.
REQ-023 WAIT: sampling done=0 SHALL set the done-low flag; done=1 with the flag set SHALL be completion.
REQ-024 WAIT: done=1 before any done=0 has been sampled in WAIT (stale done from the previous operation) SHALL be ignored.
REQ-025 On completion, product SHALL be registered into out_data, out_valid SHALL be set, and the FSM SHALL go to HOLD.
REQ-026 HOLD: out_valid and out_data SHALL stay stable until out_ready=1; at that edge out_valid SHALL clear and the FSM SHALL go to IDLE.
REQ-027 op_a/op_b SHALL remain stable from LAUNCH through HOLD.
REQ-028 wait_cnt SHALL increment each WAIT cycle and saturate at 2^5-1.
REQ-029 Minimum accept-to-out_valid latency SHALL be 3 cycles: LAUNCH, one WAIT cycle with done=0, one WAIT cycle with done=1.

Reset
REQ-030 rst_n=0 SHALL asynchronously force IDLE and clear op_a, op_b, out_data, out_valid, start, wait_cnt, the done-low flag and timeout_err, from any state.
REQ-031 Reset mid-operation SHALL discard the in-flight result, and no out_valid SHALL appear afterwards for it.
REQ-032 After reset release, in_ready SHALL be 1 in the first cycle.

Configuration
REQ-033 With MULT_DISPATCH_TIMEOUT_EN defined, reaching wait_cnt==TIMEOUT in WAIT without completion SHALL set timeout_err (sticky until reset) and return the FSM to IDLE without asserting out_valid.
REQ-034 Without MULT_DISPATCH_TIMEOUT_EN, timeout_err SHALL be tied 0 and WAIT SHALL persist until completion.

Verification
REQ-035 Bench: in_a=8'd12, in_b=8'd10; done rises 5 cycles after start, product=16'd120 -> one start pulse, out_valid with out_data=120, busy high throughout.
REQ-036 Bench: done held 1 from the previous operation through LAUNCH and the first WAIT cycle, then 0, then 1 -> completion only on the second rise, not the stale level.
REQ-037 Bench: out_ready held 0 for 4 cycles in HOLD, in_valid=1 -> out_data stable, in_ready=0, no second start; out_ready=1 -> IDLE next cycle.
REQ-038 Bench: rst_n pulsed low during WAIT -> all outputs 0 immediately; a later done=1 produces no out_valid.
REQ-039 Bench with MULT_DISPATCH_TIMEOUT_EN, TIMEOUT=15, done held 0 -> timeout_err=1 after 15 WAIT cycles, out_valid never set; next operand accepted normally, timeout_err stays 1.

Source files
------------

// File: rtl/mult_dispatch.sv
// Operand dispatcher and result catcher for an external multiplier controller.
// Optional WAIT-state abort is enabled with `define MULT_DISPATCH_TIMEOUT_EN.
module mult_dispatch #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               in_ready,
    output logic               start,
    output logic [WIDTH-1:0]   op_a,
    output logic [WIDTH-1:0]   op_b,
    input  logic               done,
    input  logic [2*WIDTH-1:0] product,
    output logic               out_valid,
    output logic [2*WIDTH-1:0] out_data,
    input  logic               out_ready,
    output logic               busy,
    output logic               timeout_err
);

`ifdef MULT_DISPATCH_TIMEOUT_EN
    localparam bit TimeoutEn = 1'b1;
`else
    localparam bit TimeoutEn = 1'b0;
`endif

    localparam logic [4:0] CntMax = 5'h1f;

    typedef enum logic [1:0] {StIdle, StLaunch, StWait, StHold} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   op_a_q, op_a_d;
    logic [WIDTH-1:0]   op_b_q, op_b_d;
    logic [2*WIDTH-1:0] out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic [4:0]         wait_cnt_q, wait_cnt_d;
    logic               done_low_q, done_low_d;
    logic               timeout_err_q, timeout_err_d;

    always_comb begin
        state_d       = state_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
        wait_cnt_d    = wait_cnt_q;
        done_low_d    = done_low_q;
        timeout_err_d = timeout_err_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    op_a_d  = in_a;
                    op_b_d  = in_b;
                    state_d = StLaunch;
                end
            end
            StLaunch: begin
                done_low_d = 1'b0;
                wait_cnt_d = '0;
                state_d    = StWait;
            end
            StWait: begin
                // A done level seen before any low sample is left over from the previous job.
                if (done && done_low_q) begin
                    out_data_d  = product;
                    out_valid_d = 1'b1;
                    state_d     = StHold;
                end else begin
                    if (!done) begin
                        done_low_d = 1'b1;
                    end
                    if (wait_cnt_q != CntMax) begin
                        wait_cnt_d = wait_cnt_q + 5'd1;
                    end
                    if (TimeoutEn && ({27'd0, wait_cnt_d} == TIMEOUT)) begin
                        timeout_err_d = 1'b1;
                        state_d       = StIdle;
                    end
                end
            end
            StHold: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            op_a_q        <= '0;
            op_b_q        <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            wait_cnt_q    <= '0;
            done_low_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            wait_cnt_q    <= wait_cnt_d;
            done_low_q    <= done_low_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign in_ready    = (state_q == StIdle);
    assign start       = (state_q == StLaunch);
    assign busy        = (state_q != StIdle);
    assign op_a        = op_a_q;
    assign op_b        = op_b_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mult_dispatch.sv
// Self-checking bench for mult_dispatch: directed scenarios plus randomized jobs
// against a product/handshake reference model.
module tb_mult_dispatch;
    localparam int unsigned W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic [W-1:0]   in_a = '0;
    logic [W-1:0]   in_b = '0;
    logic           in_ready;
    logic           start;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic           done = 1'b0;
    logic [2*W-1:0] product = '0;
    logic           out_valid;
    logic [2*W-1:0] out_data;
    logic           out_ready = 1'b0;
    logic           busy;
    logic           timeout_err;

    int checks = 0;
    int failures = 0;
    int start_cnt = 0;

    mult_dispatch #(.WIDTH(W), .TIMEOUT(15)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_ready   (in_ready),
        .start      (start),
        .op_a       (op_a),
        .op_b       (op_b),
        .done       (done),
        .product    (product),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (start) start_cnt <= start_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // One job: accept, optional stale done, `delay` low WAIT cycles, completion, `hold` stalls.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int delay,
                          input bit stale, input int hold);
        logic [2*W-1:0] exp_p;
        int s0;
        exp_p = a * b;
        chk("idle_ready", in_ready, 1);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        step;
        in_valid = 1'b0;
        in_a = W'($urandom);
        in_b = W'($urandom);
        s0 = start_cnt;
        chk("launch_start", start, 1);
        chk("launch_busy", busy, 1);
        chk("launch_ready", in_ready, 0);
        chk("launch_opa", op_a, a);
        chk("launch_opb", op_b, b);
        if (stale) begin
            done = 1'b1;
            product = ~exp_p;
            step;
            step;
            chk("stale_ignored", out_valid, 0);
            chk("stale_busy", busy, 1);
        end else begin
            done = 1'b0;
            step;
        end
        for (int i = 0; i < delay; i++) begin
            done = 1'b0;
            step;
            chk("wait_valid", out_valid, 0);
            chk("wait_busy", busy, 1);
            chk("wait_start", start, 0);
            chk("wait_opa", op_a, a);
        end
        done = 1'b1;
        product = exp_p;
        step;
        product = 16'($urandom);
        chk("done_valid", out_valid, 1);
        chk("done_data", out_data, exp_p);
        chk("done_busy", busy, 1);
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            in_valid = 1'b1;
            in_a = W'($urandom);
            step;
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, exp_p);
            chk("hold_ready", in_ready, 0);
            chk("hold_start", start, 0);
            chk("hold_opb", op_b, b);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step;
        out_ready = 1'b0;
        chk("rel_valid", out_valid, 0);
        chk("rel_ready", in_ready, 1);
        chk("rel_busy", busy, 0);
        chk("one_start", start_cnt - s0, 1);
    endtask

    initial begin
        #12;
        chk("rst_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_start", start, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_opa", op_a, 0);
        chk("rst_terr", timeout_err, 0);
        rst_n = 1'b1;
        step;
        chk("post_rst_ready", in_ready, 1);

        run_op(8'd12, 8'd10, 4, 1'b0, 0);
        run_op(8'd7, 8'd9, 2, 1'b1, 0);
        run_op(8'd200, 8'd255, 1, 1'b0, 4);
        run_op(8'd255, 8'd255, 1, 1'b1, 1);

        // Reset mid-WAIT discards the job.
        in_valid = 1'b1;
        in_a = 8'd3;
        in_b = 8'd5;
        step;
        in_valid = 1'b0;
        done = 1'b0;
        step;
        step;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_start", start, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_opa", op_a, 0);
        chk("arst_opb", op_b, 0);
        chk("arst_data", out_data, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("arst_ready", in_ready, 1);
        done = 1'b1;
        product = 16'd15;
        for (int i = 0; i < 3; i++) begin
            step;
            chk("arst_no_valid", out_valid, 0);
            chk("arst_idle", busy, 0);
        end

`ifdef MULT_DISPATCH_TIMEOUT_EN
        in_valid = 1'b1;
        in_a = 8'd9;
        in_b = 8'd11;
        step;
        in_valid = 1'b0;
        done = 1'b0;
        step;
        for (int k = 1; k <= 14; k++) begin
            step;
            chk("to_pending", timeout_err, 0);
            chk("to_busy", busy, 1);
        end
        step;
        chk("to_err", timeout_err, 1);
        chk("to_idle", busy, 0);
        chk("to_no_valid", out_valid, 0);
        run_op(8'd6, 8'd7, 3, 1'b0, 0);
        chk("to_sticky", timeout_err, 1);
`else
        run_op(8'd21, 8'd13, 20, 1'b0, 0);
        chk("no_timeout", timeout_err, 0);
`endif

        for (int n = 0; n < 25; n++) begin
            run_op(W'($urandom), W'($urandom), int'($urandom_range(1, 10)),
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
